// File: rtl/alu.sv
// Registered 32-bit ALU with carry/sign/overflow/zero flags and a sticky halt state.
// Define ALU_MUL_EN to enable the MUL opcode (01111); otherwise it behaves as NOP.
module alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] operando_a,
  input  logic [WIDTH-1:0] operando_b,
  input  logic [4:0]       opcode,
  output logic [WIDTH-1:0] resultado,
  output logic             C,
  output logic             S,
  output logic             O,
  output logic             Z,
  output logic             halted
);

  localparam logic [4:0] OpNop  = 5'b00000;
  localparam logic [4:0] OpAdd  = 5'b00001;
  localparam logic [4:0] OpSub  = 5'b00010;
  localparam logic [4:0] OpAnd  = 5'b00011;
  localparam logic [4:0] OpOr   = 5'b00100;
  localparam logic [4:0] OpXor  = 5'b00101;
  localparam logic [4:0] OpNot  = 5'b00110;
  localparam logic [4:0] OpNeg  = 5'b00111;
  localparam logic [4:0] OpShl  = 5'b01000;
  localparam logic [4:0] OpShr  = 5'b01001;
  localparam logic [4:0] OpSar  = 5'b01010;
  localparam logic [4:0] OpInc  = 5'b01011;
  localparam logic [4:0] OpDec  = 5'b01100;
  localparam logic [4:0] OpCmp  = 5'b01101;
  localparam logic [4:0] OpPass = 5'b01110;
`ifdef ALU_MUL_EN
  localparam logic [4:0] OpMul  = 5'b01111;
`endif
  localparam logic [4:0] OpHlt  = 5'b11111;

  localparam logic [WIDTH-1:0] One  = WIDTH'(1);
  localparam logic [WIDTH-1:0] Zero = '0;

  // Packs {overflow, carry/borrow, result}; subtraction carry is the unsigned borrow.
  function automatic logic [WIDTH+1:0] arith(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic             sub);
    logic [WIDTH:0] t;
    logic           ov;
    if (sub) begin
      t  = {1'b0, x} - {1'b0, y};
      ov = (x[WIDTH-1] != y[WIDTH-1]) && (t[WIDTH-1] != x[WIDTH-1]);
    end else begin
      t  = {1'b0, x} + {1'b0, y};
      ov = (x[WIDTH-1] == y[WIDTH-1]) && (t[WIDTH-1] != x[WIDTH-1]);
    end
    return {ov, t};
  endfunction

  logic [WIDTH-1:0] res_q, res_d;
  logic             c_q, c_d, s_q, s_d, o_q, o_d, z_q, z_d;
  logic             halted_q, halted_d;

  logic [WIDTH+1:0] add_r, sub_r, inc_r, dec_r, neg_r;
  logic [WIDTH:0]   shl_w, shr_w, sar_w;
  logic [4:0]       sh_amt;

  assign sh_amt = operando_b[4:0];

  // Unary ops use constant second operands so operando_b cannot leak into them.
  assign add_r = arith(operando_a, operando_b, 1'b0);
  assign sub_r = arith(operando_a, operando_b, 1'b1);
  assign inc_r = arith(operando_a, One, 1'b0);
  assign dec_r = arith(operando_a, One, 1'b1);
  assign neg_r = arith(Zero, operando_a, 1'b1);

  // One guard bit catches the last bit shifted out; amount 0 leaves it at 0.
  assign shl_w = {1'b0, operando_a} << sh_amt;
  assign shr_w = {operando_a, 1'b0} >> sh_amt;
  assign sar_w = $unsigned($signed({operando_a, 1'b0}) >>> sh_amt);

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] mul_u, mul_s;
  logic               mul_ovf;
  assign mul_u   = {{WIDTH{1'b0}}, operando_a} * {{WIDTH{1'b0}}, operando_b};
  assign mul_s   = $unsigned($signed({{WIDTH{operando_a[WIDTH-1]}}, operando_a}) *
                             $signed({{WIDTH{operando_b[WIDTH-1]}}, operando_b}));
  assign mul_ovf = mul_s != {{WIDTH{mul_s[WIDTH-1]}}, mul_s[WIDTH-1:0]};
`endif

  logic             wr;
  logic [WIDTH-1:0] r;
  logic             cf, of;

  always_comb begin
    res_d    = res_q;
    c_d      = c_q;
    s_d      = s_q;
    o_d      = o_q;
    z_d      = z_q;
    halted_d = halted_q;
    wr       = 1'b0;
    r        = '0;
    cf       = 1'b0;
    of       = 1'b0;
    if (!halted_q) begin
      case (opcode)
        OpAdd:  begin wr = 1'b1; {of, cf, r} = add_r; end
        OpSub:  begin wr = 1'b1; {of, cf, r} = sub_r; end
        OpInc:  begin wr = 1'b1; {of, cf, r} = inc_r; end
        OpDec:  begin wr = 1'b1; {of, cf, r} = dec_r; end
        OpNeg:  begin wr = 1'b1; {of, cf, r} = neg_r; end
        OpAnd:  begin wr = 1'b1; r = operando_a & operando_b; end
        OpOr:   begin wr = 1'b1; r = operando_a | operando_b; end
        OpXor:  begin wr = 1'b1; r = operando_a ^ operando_b; end
        OpNot:  begin wr = 1'b1; r = ~operando_a; end
        OpPass: begin wr = 1'b1; r = operando_a; end
        OpShl:  begin wr = 1'b1; r = shl_w[WIDTH-1:0]; cf = shl_w[WIDTH]; end
        OpShr:  begin wr = 1'b1; r = shr_w[WIDTH:1];   cf = shr_w[0]; end
        OpSar:  begin wr = 1'b1; r = sar_w[WIDTH:1];   cf = sar_w[0]; end
`ifdef ALU_MUL_EN
        OpMul: begin
          wr = 1'b1;
          r  = mul_u[WIDTH-1:0];
          cf = |mul_u[2*WIDTH-1:WIDTH];
          of = mul_ovf;
        end
`endif
        // Flags come from the difference while resultado keeps its value.
        OpCmp: begin
          c_d = sub_r[WIDTH];
          o_d = sub_r[WIDTH+1];
          s_d = sub_r[WIDTH-1];
          z_d = sub_r[WIDTH-1:0] == '0;
        end
        OpHlt:  halted_d = 1'b1;
        OpNop:  ;
        default: ;
      endcase
      if (wr) begin
        res_d = r;
        c_d   = cf;
        o_d   = of;
        s_d   = r[WIDTH-1];
        z_d   = r == '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q    <= '0;
      c_q      <= 1'b0;
      s_q      <= 1'b0;
      o_q      <= 1'b0;
      z_q      <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      res_q    <= res_d;
      c_q      <= c_d;
      s_q      <= s_d;
      o_q      <= o_d;
      z_q      <= z_d;
      halted_q <= halted_d;
    end
  end

  assign resultado = res_q;
  assign C         = c_q;
  assign S         = s_q;
  assign O         = o_q;
  assign Z         = z_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu: a behavioural model checked every cycle plus literal pins.
module tb_alu;

  logic        clk, rst_n, clk_run;
  logic [31:0] operando_a, operando_b;
  logic [4:0]  opcode;
  logic [31:0] resultado;
  logic        C, S, O, Z, halted;

  alu #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .operando_a (operando_a),
    .operando_b (operando_b),
    .opcode     (opcode),
    .resultado  (resultado),
    .C          (C),
    .S          (S),
    .O          (O),
    .Z          (Z),
    .halted     (halted)
  );

  always #5 if (clk_run) clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state: what the registered outputs must be.
  logic [31:0] m_r;
  logic        m_c, m_s, m_o, m_z, m_h;

  // Literal expectation for the current cycle.
  bit          lit_en;
  logic [31:0] lit_r;
  logic [3:0]  lit_f;
  logic        lit_h;
  string       lit_nm;
  event        chk_ev;

  function automatic longint sx(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic bit ovf(input longint v);
    logic [63:0] u;
    u = v;
    return u != {{32{u[31]}}, u[31:0]};
  endfunction

  task automatic put(input logic [31:0] r, input logic c, input logic o);
    m_r = r; m_c = c; m_o = o; m_s = r[31]; m_z = (r == 32'd0);
  endtask

  task automatic m_add(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] w;
    w = {32'd0, a} + {32'd0, b};
    put(w[31:0], w[32], ovf(sx(a) + sx(b)));
  endtask

  task automatic m_sub(input logic [31:0] a, input logic [31:0] b);
    put(a - b, a < b, ovf(sx(a) - sx(b)));
  endtask

  task automatic model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int          n;
    logic [31:0] keep;
    logic [63:0] w;
    if (m_h) return;
    n = int'(b[4:0]);
    case (op)
      5'h01: m_add(a, b);
      5'h02: m_sub(a, b);
      5'h03: put(a & b, 1'b0, 1'b0);
      5'h04: put(a | b, 1'b0, 1'b0);
      5'h05: put(a ^ b, 1'b0, 1'b0);
      5'h06: put(~a, 1'b0, 1'b0);
      5'h07: put(32'd0 - a, a != 32'd0, ovf(-sx(a)));
      5'h08: put(a << n, (n != 0) ? a[32 - n] : 1'b0, 1'b0);
      5'h09: put(a >> n, (n != 0) ? a[n - 1] : 1'b0, 1'b0);
      5'h0A: put(32'($signed(a) >>> n), (n != 0) ? a[n - 1] : 1'b0, 1'b0);
      5'h0B: m_add(a, 32'd1);
      5'h0C: m_sub(a, 32'd1);
      5'h0D: begin keep = m_r; m_sub(a, b); m_r = keep; end
      5'h0E: put(a, 1'b0, 1'b0);
`ifdef ALU_MUL_EN
      5'h0F: begin
        w = {32'd0, a} * {32'd0, b};
        put(w[31:0], w[63:32] != 32'd0, ovf(sx(a) * sx(b)));
      end
`endif
      5'h1F: m_h = 1'b1;
      default: ;
    endcase
  endtask

  task automatic model_reset();
    m_r = 32'd0; m_c = 0; m_s = 0; m_o = 0; m_z = 0; m_h = 0;
  endtask

  // Single compare process: model check every cycle, literal pins when requested.
  always begin
    @(negedge clk or chk_ev);
    total++;
    if ({resultado, C, S, O, Z, halted} !== {m_r, m_c, m_s, m_o, m_z, m_h}) begin
      bad++;
      $display("FAIL model t=%0t got r=%h CSOZ=%b%b%b%b h=%b want r=%h CSOZ=%b%b%b%b h=%b",
               $time, resultado, C, S, O, Z, halted, m_r, m_c, m_s, m_o, m_z, m_h);
    end
    if (lit_en) begin
      total++;
      if (resultado !== lit_r) begin
        bad++;
        $display("FAIL %s result got %h want %h", lit_nm, resultado, lit_r);
      end
      total++;
      if ({C, S, O, Z} !== lit_f) begin
        bad++;
        $display("FAIL %s CSOZ got %b want %b", lit_nm, {C, S, O, Z}, lit_f);
      end
      total++;
      if (halted !== lit_h) begin
        bad++;
        $display("FAIL %s halted got %b want %b", lit_nm, halted, lit_h);
      end
      total++;
      if ({m_r, m_c, m_s, m_o, m_z, m_h} !== {lit_r, lit_f, lit_h}) begin
        bad++;
        $display("FAIL %s model-pin got r=%h CSOZ=%b%b%b%b want r=%h CSOZ=%b",
                 lit_nm, m_r, m_c, m_s, m_o, m_z, lit_r, lit_f);
      end
    end
  end

  task automatic step(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input bit dl, input logic [31:0] lr, input logic [3:0] lf,
                      input logic lh, input string nm);
    opcode = op; operando_a = a; operando_b = b;
    @(posedge clk);
    model(op, a, b);
    lit_en = dl; lit_r = lr; lit_f = lf; lit_h = lh; lit_nm = nm;
    @(negedge clk);
    #1 lit_en = 0;
  endtask

  initial begin
    clk = 0; clk_run = 0; rst_n = 1; lit_en = 0;
    opcode = 5'h01; operando_a = 32'hDEADBEEF; operando_b = 32'h12345678;
    model_reset();
    #1 rst_n = 0;
    #1 lit_r = 32'd0; lit_f = 4'b0000; lit_h = 0; lit_nm = "reset_noclk"; lit_en = 1;
    -> chk_ev;
    #1 lit_en = 0;
    #5 clk_run = 1;
    repeat (2) @(negedge clk);
    #1 rst_n = 1;

    step(5'h01, 32'hFFFF0000, 32'hFFFFFFFF, 1, 32'hFFFEFFFF, 4'b1100, 0, "add1");
    step(5'h01, 32'h80000000, 32'h80000000, 1, 32'h00000000, 4'b1011, 0, "add_ovf");
    step(5'h04, 32'hFFFF0000, 32'h0000FFFF, 1, 32'hFFFFFFFF, 4'b0100, 0, "or");
    step(5'h03, 32'h00001111, 32'h10100011, 1, 32'h00000011, 4'b0000, 0, "and");
    step(5'h02, 32'hFFFFFFFF, 32'h00000001, 1, 32'hFFFFFFFE, 4'b0100, 0, "sub1");
    step(5'h02, 32'h00000000, 32'h00000001, 1, 32'hFFFFFFFF, 4'b1100, 0, "sub_borrow");
    step(5'h0D, 32'h00000005, 32'h00000005, 1, 32'hFFFFFFFF, 4'b0001, 0, "cmp_eq");
    step(5'h07, 32'hFFFFFFFF, 32'h00000000, 1, 32'h00000001, 4'b1000, 0, "neg");
    step(5'h06, 32'h0000FFFF, 32'hxxxxxxxx, 1, 32'hFFFF0000, 4'b0100, 0, "not_bx");
    step(5'h00, 32'h13579BDF, 32'h2468ACE0, 1, 32'hFFFF0000, 4'b0100, 0, "nop_hold");
    step(5'h0A, 32'h80000000, 32'h0000001F, 1, 32'hFFFFFFFF, 4'b0100, 0, "sar31");
    step(5'h08, 32'h80000001, 32'h00000001, 1, 32'h00000002, 4'b1000, 0, "shl1");
    step(5'h09, 32'h00000003, 32'h00000001, 1, 32'h00000001, 4'b1000, 0, "shr1");
    step(5'h08, 32'hC0FFEE00, 32'hFFFFFFE0, 1, 32'hC0FFEE00, 4'b0100, 0, "shl0");
    step(5'h0B, 32'h7FFFFFFF, 32'hxxxxxxxx, 1, 32'h80000000, 4'b0110, 0, "inc_ovf");
    step(5'h0C, 32'h00000000, 32'hxxxxxxxx, 1, 32'hFFFFFFFF, 4'b1100, 0, "dec0");
    step(5'h07, 32'h80000000, 32'hxxxxxxxx, 1, 32'h80000000, 4'b1110, 0, "neg_min");
    step(5'h0E, 32'h12345678, 32'hxxxxxxxx, 1, 32'h12345678, 4'b0000, 0, "pass");
    step(5'h10, 32'h00000000, 32'h00000000, 1, 32'h12345678, 4'b0000, 0, "unassigned");
`ifdef ALU_MUL_EN
    step(5'h0F, 32'h00010000, 32'h00010000, 1, 32'h00000000, 4'b1011, 0, "mul");
`else
    step(5'h0F, 32'h00010000, 32'h00010000, 1, 32'h12345678, 4'b0000, 0, "mul_off");
`endif
    step(5'h05, 32'hAAAA5555, 32'hFFFF0000, 1, 32'h55555555, 4'b0000, 0, "xor");
    step(5'h02, 32'h00000001, 32'h00000003, 0, 32'h0, 4'b0, 0, "sub_neg");
    step(5'h05, 32'hAAAA5555, 32'hFFFF0000, 1, 32'h55555555, 4'b0000, 0, "xor2");
    step(5'h1F, 32'h00000000, 32'h00000000, 1, 32'h55555555, 4'b0000, 1, "hlt");
    step(5'h01, 32'h00000001, 32'h00000001, 1, 32'h55555555, 4'b0000, 1, "add_halted");
    step(5'h02, 32'h00000000, 32'h00000001, 0, 32'h0, 4'b0, 0, "sub_halted");

    // Asynchronous reset in the middle of a cycle.
    #2 rst_n = 0;
    model_reset();
    #1 lit_r = 32'd0; lit_f = 4'b0000; lit_h = 0; lit_nm = "reset_async"; lit_en = 1;
    -> chk_ev;
    #1 lit_en = 0;
    @(negedge clk);
    #1 rst_n = 1;
    step(5'h01, 32'h00000001, 32'h00000001, 1, 32'h00000002, 4'b0000, 0, "add_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
